// File: rtl/unified_mem_arbiter_if.sv
// Bundle between the pipeline fetch/memory stages, the shared memory and the arbiter.
// master = pipeline + memory side, slave = arbiter.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              dm_rd;
    logic              dm_wr;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [15:0]       conflict_cnt;

    modport master (
        output if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ready, dm_rdata, dm_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata, conflict_cnt
    );

    modport slave (
        input  if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ready, dm_rdata, dm_ready,
        output mem_en, mem_we, mem_addr, mem_wdata, conflict_cnt
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one fixed-latency single-port memory between fetch and load/store.
// Data requests win; each access holds the bus MEM_LAT cycles, then one ready pulse.
module unified_mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input logic               clk,
    input logic               reset,
    unified_mem_arbiter_if.slave io_bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    localparam logic       OWN_IF = 1'b0;
    localparam logic       OWN_DM = 1'b1;
    localparam logic [3:0] LAST   = 4'(MEM_LAT - 1);

    state_t            r_state;
    state_t            w_next;
    logic              r_owner;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic [15:0]       r_conflict;

    logic w_dm_req;
    logic w_grant_dm;
    logic w_grant_if;
    logic w_last;

    assign w_dm_req = io_bus.dm_rd | io_bus.dm_wr;
    assign w_last   = (r_state == S_BUSY) && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // In RESP only the other requester may win; the owner still holds its lines.
    always_comb begin
        w_next     = r_state;
        w_grant_dm = 1'b0;
        w_grant_if = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_dm_req)           w_grant_dm = 1'b1;
                else if (io_bus.if_req) w_grant_if = 1'b1;
            end
            S_BUSY: begin
                if (r_cnt == LAST) w_next = S_RESP;
            end
            S_RESP: begin
                w_next = S_IDLE;
                if (r_owner == OWN_IF && w_dm_req)
                    w_grant_dm = 1'b1;
                else if (r_owner == OWN_DM && io_bus.if_req)
                    w_grant_if = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_grant_dm || w_grant_if) w_next = S_BUSY;
    end

    always_comb begin
        io_bus.mem_en       = (r_state == S_BUSY);
        io_bus.mem_we       = (r_state == S_BUSY) && r_we;
        io_bus.mem_addr     = r_addr;
        io_bus.mem_wdata    = r_wdata;
        io_bus.if_rdata     = r_if_rdata;
        io_bus.dm_rdata     = r_dm_rdata;
        io_bus.if_ready     = (r_state == S_RESP) && (r_owner == OWN_IF)
                              && io_bus.if_req;
        io_bus.dm_ready     = (r_state == S_RESP) && (r_owner == OWN_DM)
                              && w_dm_req;
        io_bus.conflict_cnt = r_conflict;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner    <= OWN_IF;
            r_cnt      <= 4'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
            r_conflict <= 16'd0;
        end else begin
            if (w_grant_dm) begin
                r_owner <= OWN_DM;
                r_cnt   <= 4'd0;
                r_addr  <= io_bus.dm_addr;
                r_wdata <= io_bus.dm_wdata;
                r_we    <= io_bus.dm_wr;
            end else if (w_grant_if) begin
                r_owner <= OWN_IF;
                r_cnt   <= 4'd0;
                r_addr  <= io_bus.if_addr;
                r_we    <= 1'b0;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_last && !r_we) begin
                if (r_owner == OWN_IF) r_if_rdata <= io_bus.mem_rdata;
                else                   r_dm_rdata <= io_bus.mem_rdata;
            end
            if (w_grant_dm && io_bus.if_req && r_conflict != 16'hFFFF)
                r_conflict <= r_conflict + 16'd1;
        end
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter with a fixed-latency memory model.
// Ready pulses are matched against queued expected data and completion cycle.
module tb_unified_mem_arbiter;
    localparam int LAT = 2;

    typedef struct {
        logic [15:0] d;
        int          c;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   run   = 0;
    int   errs  = 0;
    int   checks = 0;
    int   T;

    logic [15:0] wmem [256];
    bit          wv   [256];
    exp_t        if_q [$];
    exp_t        dm_q [$];

    always #5 clk = ~clk;

    unified_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    unified_mem_arbiter #(
        .ADDR_W(16),
        .DATA_W(16),
        .MEM_LAT(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .io_bus(bus.slave)
    );

    function automatic logic [15:0] rom(input logic [15:0] a);
        case (a)
            16'h0010: return 16'h1234;
            16'h0020: return 16'h5678;
            16'h0100: return 16'hA5A5;
            default:  return a ^ 16'h5A5A;
        endcase
    endfunction

    function automatic logic [15:0] rd(input logic [15:0] a);
        logic [7:0] i;
        i = a[7:0];
        if (wv[i]) return wmem[i];
        return rom(a);
    endfunction

    // Memory model: data valid only in the LAT-th consecutive enabled cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        run <= bus.mem_en ? run + 1 : 0;
        if (bus.mem_en && bus.mem_we && run == LAT - 1) begin
            wmem[bus.mem_addr[7:0]] <= bus.mem_wdata;
            wv[bus.mem_addr[7:0]]   <= 1'b1;
        end
    end

    always_comb begin
        bus.mem_rdata = 16'hDEAD;
        if (bus.mem_en && run == LAT - 1) bus.mem_rdata = rd(bus.mem_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mon();
        exp_t e;
        @(negedge clk);
        if (bus.if_ready) begin
            checks++;
            if (if_q.size() == 0) begin
                errs++;
                $display("FAIL if_ready_unexpected: got 1 at cycle %0d, required 0", cyc);
            end else begin
                e = if_q.pop_front();
                if (bus.if_rdata !== e.d || cyc != e.c) begin
                    errs++;
                    $display("FAIL if_resp: got %h at cycle %0d, required %h at cycle %0d",
                             bus.if_rdata, cyc, e.d, e.c);
                end
            end
        end
        if (bus.dm_ready) begin
            checks++;
            if (dm_q.size() == 0) begin
                errs++;
                $display("FAIL dm_ready_unexpected: got 1 at cycle %0d, required 0", cyc);
            end else begin
                e = dm_q.pop_front();
                if (bus.dm_rdata !== e.d || cyc != e.c) begin
                    errs++;
                    $display("FAIL dm_resp: got %h at cycle %0d, required %h at cycle %0d",
                             bus.dm_rdata, cyc, e.d, e.c);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) begin
            tick();
            mon();
        end
        checks++;
        if ({bus.mem_en, bus.mem_we, bus.if_ready, bus.dm_ready} !== 4'b0) begin
            errs++;
            $display("FAIL rst_ctrl: got %b, required 0000",
                     {bus.mem_en, bus.mem_we, bus.if_ready, bus.dm_ready});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata} !== 32'h0) begin
            errs++;
            $display("FAIL rst_bus: got %h, required 0", {bus.mem_addr, bus.mem_wdata});
        end
        checks++;
        if ({bus.if_rdata, bus.dm_rdata} !== 32'h0) begin
            errs++;
            $display("FAIL rst_rdata: got %h, required 0", {bus.if_rdata, bus.dm_rdata});
        end
        checks++;
        if (bus.conflict_cnt !== 16'h0) begin
            errs++;
            $display("FAIL rst_conflict: got %h, required 0", bus.conflict_cnt);
        end
        tick();
        reset = 1'b0;
        mon();
    endtask

    task automatic test_single_fetch();
        logic exp_en;
        tick();
        T = cyc;
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0010;
        if_q.push_back('{16'h1234, T + 3});
        mon();
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 4) bus.if_req = 1'b0;
            mon();
            exp_en = (k <= 2);
            checks++;
            if (bus.mem_en !== exp_en) begin
                errs++;
                $display("FAIL fetch_mem_en: got %b at T+%0d, required %b", bus.mem_en, k, exp_en);
            end
            if (k <= 2) begin
                checks++;
                if (bus.mem_addr !== 16'h0010 || bus.mem_we !== 1'b0) begin
                    errs++;
                    $display("FAIL fetch_bus: got addr %h we %b, required 0010 0",
                             bus.mem_addr, bus.mem_we);
                end
            end
        end
        checks++;
        if (if_q.size() != 0) begin
            errs++;
            $display("FAIL fetch_timeout: got %0d pending, required 0", if_q.size());
        end
    endtask

    task automatic run_conflict(input logic [15:0] exp_cnt);
        tick();
        T = cyc;
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0020;
        bus.dm_rd   = 1'b1;
        bus.dm_addr = 16'h0100;
        dm_q.push_back('{16'hA5A5, T + 3});
        if_q.push_back('{16'h5678, T + 6});
        mon();
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 4) bus.dm_rd = 1'b0;
            if (k == 7) bus.if_req = 1'b0;
            mon();
            if (k == 4) begin
                checks++;
                if (bus.mem_en !== 1'b1 || bus.mem_addr !== 16'h0020) begin
                    errs++;
                    $display("FAIL conflict_fetch_busy: got en %b addr %h, required 1 0020",
                             bus.mem_en, bus.mem_addr);
                end
            end
        end
        checks++;
        if (bus.conflict_cnt !== exp_cnt) begin
            errs++;
            $display("FAIL conflict_cnt: got %h, required %h", bus.conflict_cnt, exp_cnt);
        end
        checks++;
        if (if_q.size() != 0 || dm_q.size() != 0) begin
            errs++;
            $display("FAIL conflict_timeout: got %0d/%0d pending, required 0/0",
                     if_q.size(), dm_q.size());
        end
    endtask

    task automatic test_conflict();
        run_conflict(16'h0001);
    endtask

    task automatic test_store();
        tick();
        T = cyc;
        bus.dm_wr    = 1'b1;
        bus.dm_addr  = 16'h0040;
        bus.dm_wdata = 16'hBEEF;
        dm_q.push_back('{16'hA5A5, T + 3});
        mon();
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 4) bus.dm_wr = 1'b0;
            mon();
            checks++;
            if (k <= 2) begin
                if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}
                    !== {2'b11, 16'h0040, 16'hBEEF}) begin
                    errs++;
                    $display("FAIL store_bus: got en %b we %b %h %h, required 1 1 0040 BEEF",
                             bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
                end
            end else if (bus.mem_we !== 1'b0) begin
                errs++;
                $display("FAIL store_we_idle: got %b, required 0", bus.mem_we);
            end
        end
        checks++;
        if (rd(16'h0040) !== 16'hBEEF) begin
            errs++;
            $display("FAIL store_commit: got %h, required BEEF", rd(16'h0040));
        end
        tick();
        T = cyc;
        bus.dm_rd    = 1'b1;
        bus.dm_wr    = 1'b1;
        bus.dm_addr  = 16'h0050;
        bus.dm_wdata = 16'h1111;
        dm_q.push_back('{16'hA5A5, T + 3});
        mon();
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 4) begin
                bus.dm_rd = 1'b0;
                bus.dm_wr = 1'b0;
            end
            mon();
        end
        checks++;
        if (rd(16'h0050) !== 16'h1111 || dm_q.size() != 0) begin
            errs++;
            $display("FAIL rdwr_as_write: got %h pending %0d, required 1111 pending 0",
                     rd(16'h0050), dm_q.size());
        end
    endtask

    task automatic test_held_request();
        logic exp_en;
        tick();
        T = cyc;
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0010;
        if_q.push_back('{16'h1234, T + 3});
        if_q.push_back('{16'h1234, T + 7});
        mon();
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 8) bus.if_req = 1'b0;
            mon();
            exp_en = (k == 1 || k == 2 || k == 5 || k == 6);
            checks++;
            if (bus.mem_en !== exp_en) begin
                errs++;
                $display("FAIL held_mem_en: got %b at T+%0d, required %b", bus.mem_en, k, exp_en);
            end
        end
        checks++;
        if (if_q.size() != 0) begin
            errs++;
            $display("FAIL held_timeout: got %0d pending, required 0", if_q.size());
        end
    endtask

    task automatic test_killed_fetch();
        tick();
        T = cyc;
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0020;
        mon();
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 2) bus.if_req = 1'b0;
            if (k == 3) begin
                bus.dm_rd   = 1'b1;
                bus.dm_addr = 16'h0100;
                dm_q.push_back('{16'hA5A5, T + 6});
            end
            if (k == 7) bus.dm_rd = 1'b0;
            mon();
            if (k == 3) begin
                checks++;
                if (bus.if_ready !== 1'b0) begin
                    errs++;
                    $display("FAIL killed_ready: got %b, required 0", bus.if_ready);
                end
            end
        end
        checks++;
        if (bus.if_rdata !== 16'h5678 || dm_q.size() != 0) begin
            errs++;
            $display("FAIL killed_after: got rdata %h pending %0d, required 5678 pending 0",
                     bus.if_rdata, dm_q.size());
        end
    endtask

    task automatic test_reset_mid();
        tick();
        T = cyc;
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0010;
        mon();
        tick();
        reset = 1'b1;
        mon();
        checks++;
        if (bus.mem_en !== 1'b1) begin
            errs++;
            $display("FAIL rmid_busy: got %b, required 1", bus.mem_en);
        end
        tick();
        bus.if_req = 1'b0;
        mon();
        checks++;
        if ({bus.mem_en, bus.if_ready, bus.dm_ready, bus.conflict_cnt,
             bus.if_rdata, bus.dm_rdata} !== 51'h0) begin
            errs++;
            $display("FAIL rmid_clear: got en %b cnt %h rdata %h/%h, required all 0",
                     bus.mem_en, bus.conflict_cnt, bus.if_rdata, bus.dm_rdata);
        end
        tick();
        reset = 1'b0;
        mon();
        for (int k = 0; k < 2; k++) begin
            tick();
            mon();
            checks++;
            if (bus.mem_en !== 1'b0) begin
                errs++;
                $display("FAIL rmid_idle: got %b, required 0", bus.mem_en);
            end
        end
    endtask

    task automatic test_saturation();
        tick();
        force dut.r_conflict = 16'hFFFE;
        #1;
        release dut.r_conflict;
        mon();
        checks++;
        if (bus.conflict_cnt !== 16'hFFFE) begin
            errs++;
            $display("FAIL sat_preload: got %h, required FFFE", bus.conflict_cnt);
        end
        run_conflict(16'hFFFF);
        run_conflict(16'hFFFF);
    endtask

    initial begin
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.dm_rd    = 1'b0;
        bus.dm_wr    = 1'b0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;
        test_reset();
        test_single_fetch();
        test_conflict();
        test_store();
        test_held_request();
        test_killed_fetch();
        test_reset_mid();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port, fixed-latency 16-bit memory between the fetch stage (instruction reads) and the memory stage (load/store).
- Replaces the separate IMEM/DMEM ports in front of the pipeline.
- Sequences each memory access over MEM_LAT cycles and returns a one-cycle ready pulse to the winning requester.
- The datapath converts a missing ready into stall/killF.

Parameters:
- ADDR_W, 16, address width of all ports.
- DATA_W, 16, data width of all ports.
- MEM_LAT, 2, cycles the memory needs per access with address held stable; legal range 1..15.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch read request; held with if_addr until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction; valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse for fetch.
- dm_rd  in  1  load request.
- dm_wr  in  1  store request.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data; valid while dm_ready=1.
- dm_ready  out  1  one-cycle completion pulse for load/store.
- mem_en  out  1  memory access active.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid in the MEM_LAT-th consecutive mem_en cycle with stable address.
- conflict_cnt  out  16  saturating count of cycles in which a fetch request lost arbitration to a data request.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset: state=IDLE; owner=FETCH; cnt=0; latched addr/wdata/we=0; rdata regs=0; all outputs 0 including conflict_cnt.
- Reset mid-access abandons the access: mem_en=0 from the next cycle and no ready pulse is issued.
- FSM states: IDLE, BUSY, RESP.
- IDLE arbitration, data wins:
  - dm_rd|dm_wr -> latch dm_addr, dm_wdata, we=dm_wr; owner=DATA.
  - else if_req -> latch if_addr, we=0; owner=FETCH.
  - Either grant sets cnt=0 and goes to BUSY. No request -> stay in IDLE.
- dm_rd and dm_wr both high: treated as a write.
- BUSY:
  - mem_en=1; mem_addr, mem_wdata and mem_we are driven from the latched registers, stable for all MEM_LAT cycles.
  - cnt increments each cycle.
  - When cnt==MEM_LAT-1: capture mem_rdata into the owner's rdata register (stores leave it unchanged) and go to RESP.
  - Requester inputs are ignored while in BUSY.
- RESP:
  - Owner's ready=1 for exactly this cycle; mem_en=0.
  - Arbitration here considers only the non-owner request. Owner's request lines are still asserted this cycle and must not be re-granted.
  - Non-owner requesting -> grant it and go to BUSY. Otherwise go to IDLE.
- Latency: request seen in IDLE at cycle T; BUSY for T+1..T+MEM_LAT; ready at T+MEM_LAT+1.
- Throughput: alternating requesters sustain one access per MEM_LAT+1 cycles.
- Request dropped before completion (e.g. fetch killed):
  - Access still runs to completion, but ready is suppressed for that access.
  - Check: requester's own request line low during RESP -> ready=0.
  - Store still commits.
- Rdata registers hold their value between accesses. ready=0 for the non-owner at all times.
- conflict_cnt increments in any cycle where if_req=1, (dm_rd|dm_wr)=1 and the arbiter grants DATA. It saturates at 16'hFFFF.
- Writes: the memory commits at the end of the last BUSY cycle; mem_we=0 outside BUSY.

Test Plan:
- Single fetch, MEM_LAT=2: if_req=1, if_addr=16'h0010, mem returns 16'h1234 in the 2nd BUSY cycle -> if_ready=1 exactly at T+3 with if_rdata=16'h1234, mem_en high for 2 cycles.
- Simultaneous if_req (16'h0020) and dm_rd (16'h0100): load served first (dm_ready at T+3); fetch granted in RESP (dm_ready cycle) and if_ready at T+6; conflict_cnt=1.
- Store: dm_wr=1, dm_addr=16'h0040, dm_wdata=16'hBEEF -> mem_we=1 and mem_addr/mem_wdata stable for 2 cycles, dm_ready at T+3, dm_rdata unchanged.
- Held request after completion: fetch keeps if_req=1 through RESP with no dm request -> arbiter returns to IDLE, regrants the fetch only at T+4, not in RESP.
- Killed fetch: if_req drops at T+2 -> access completes, if_ready stays 0, next dm_rd is granted normally.
- Reset at T+1 of an access -> mem_en=0 at T+2, no ready pulse, all outputs and conflict_cnt read 0; conflict saturation check: preload conflict_cnt=16'hFFFF via forced conflicts -> stays 16'hFFFF.
